dm_timer_responder: RTL and testbench

//  Responder end of the M-stage data bus: serves m_data_addr/byteen/wdata and returns m_data_rdata.

---
 rtl/dm_timer_responder.sv | 157 +++++++++++++++
 tb/tb_dm_timer_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dm_timer_responder.sv
// dm_timer_responder: responder end of the M-stage data bus.
// Holds a byte-enabled data memory and a memory-mapped countdown timer (TC) whose interrupt
// request feeds CP0.
//
// Ports:
//   Clk            system clock, all state updates on the rising edge
//   Rst            synchronous active-high reset
//   m_data_addr    byte address from M stage (bits [1:0] ignored, word access)
//   m_data_byteen  byte write enables, 4'b0000 means read only
//   m_data_wdata   lane-aligned write data
//   m_inst_addr    PC of the M-stage instruction (trace only, unused by the logic)
//   m_data_rdata   read word, combinational from m_data_addr
//   irq            registered timer interrupt request (irq_flag & IM, one cycle behind)
//
// Timer map at TC_BASE: +0 CTRL {IM, MODE[1:0], EN}, +4 PRESET, +8 COUNT (read-only).
module dm_timer_responder #(
    parameter int unsigned DM_WORDS = 3072,
    parameter logic [31:0] DM_BASE  = 32'h0000_0000,
    parameter logic [31:0] TC_BASE  = 32'h0000_7F00
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] m_data_addr,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_wdata,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        irq
);

    localparam int unsigned AW       = $clog2(DM_WORDS);
    localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);

    typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} tc_state_e;

    logic [31:0] mem_q [DM_WORDS];
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_flag_q;
    tc_state_e   state_q;

    logic [31:0]   dm_off;
    logic [AW-1:0] dm_idx;
    logic          dm_hit;
    logic          tc_hit;
    logic          tc_wr;
    logic          ctrl_wr;
    logic          preset_wr;
    logic          auto_reload;
    logic          unused_bits;

    // Unsigned wrap makes addresses below DM_BASE land far outside DM_BYTES.
    assign dm_off = m_data_addr - DM_BASE;
    assign dm_idx = dm_off[AW+1:2];
    assign dm_hit = dm_off < DM_BYTES;
    assign tc_hit = !dm_hit && (m_data_addr[31:4] == TC_BASE[31:4])
                    && (m_data_addr[3:2] != 2'b11);

    // Timer registers only accept full-word writes; COUNT is never written by the bus.
    assign tc_wr       = tc_hit && (m_data_byteen == 4'b1111);
    assign ctrl_wr     = tc_wr && (m_data_addr[3:2] == 2'b00);
    assign preset_wr   = tc_wr && (m_data_addr[3:2] == 2'b01);
    assign auto_reload = ctrl_q[2:1] == 2'b01;

    assign unused_bits = ^{m_inst_addr, dm_off[31:AW+2], dm_off[1:0]};

    // Data memory: per-lane byte merge, whole array cleared on reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int unsigned i = 0; i < DM_WORDS; i++) begin
                mem_q[AW'(i)] <= '0;
            end
        end else if (dm_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (m_data_byteen[b]) begin
                    mem_q[dm_idx][8*b +: 8] <= m_data_wdata[8*b +: 8];
                end
            end
        end
    end

    // Timer FSM and its registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= StIdle;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            irq        <= 1'b0;
        end else begin
            irq <= irq_flag_q & ctrl_q[3];

            if (preset_wr) begin
                preset_q <= m_data_wdata;
            end

            // Auto-reload flag lives for exactly the cycle after INT; one-shot holds until
            // software rewrites CTRL.
            if (state_q == StInt) begin
                irq_flag_q <= 1'b1;
            end else if (ctrl_wr || auto_reload) begin
                irq_flag_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (ctrl_q[0]) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    count_q <= preset_q;
                    state_q <= StCnt;
                end
                StCnt: begin
                    if (!ctrl_q[0]) begin
                        state_q <= StIdle;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_q - 32'd1;
                    end else begin
                        count_q <= '0;
                        state_q <= StInt;
                    end
                end
                StInt: begin
                    if (!auto_reload) begin
                        ctrl_q[0] <= 1'b0;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // Placed last so a bus write overrides the FSM clearing EN in the same cycle.
            if (ctrl_wr) begin
                ctrl_q <= m_data_wdata[3:0];
            end
        end
    end

    always_comb begin
        m_data_rdata = '0;
        if (dm_hit) begin
            m_data_rdata = mem_q[dm_idx];
        end else if (tc_hit) begin
            case (m_data_addr[3:2])
                2'b00:   m_data_rdata = {28'd0, ctrl_q};
                2'b01:   m_data_rdata = preset_q;
                2'b10:   m_data_rdata = count_q;
                default: m_data_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_timer_responder.sv
// Directed bench for dm_timer_responder: DM merge, read-during-write, one-shot and
// auto-reload timer, decode boundaries and mid-count reset.
module tb_dm_timer_responder;

    localparam logic [31:0] TC = 32'h0000_7F00;

    logic        Clk;
    logic        Rst;
    logic [31:0] m_data_addr;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_wdata;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    dm_timer_responder dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .m_data_addr  (m_data_addr),
        .m_data_byteen(m_data_byteen),
        .m_data_wdata (m_data_wdata),
        .m_inst_addr  (m_inst_addr),
        .m_data_rdata (m_data_rdata),
        .irq          (irq)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; one rising edge performs the write.
    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        m_data_addr   = a;
        m_data_byteen = be;
        m_data_wdata  = d;
        @(negedge Clk);
        m_data_byteen = 4'b0000;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        m_data_addr   = a;
        m_data_byteen = 4'b0000;
        #1;
        check(tag, m_data_rdata, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    initial begin
        Rst           = 1'b1;
        m_data_addr   = '0;
        m_data_byteen = '0;
        m_data_wdata  = '0;
        m_inst_addr   = 32'h0000_3000;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;

        // Reset state
        rd("rst_ctrl", TC, 32'h0);
        rd("rst_preset", TC + 4, 32'h0);
        rd("rst_count", TC + 8, 32'h0);
        rd("rst_dm0", 32'h0, 32'h0);
        chk_irq("rst_irq", 1'b0);

        // DM byte merge
        wr(32'h10, 4'b1111, 32'h1122_3344);
        rd("dm_full", 32'h10, 32'h1122_3344);
        wr(32'h10, 4'b0100, 32'hAABB_CCDD);
        rd("dm_merge", 32'h10, 32'h11BB_3344);
        wr(32'h13, 4'b0001, 32'h0000_0077);
        rd("dm_addr_lsb_ignored", 32'h10, 32'h11BB_3377);

        // Read during write returns the old word
        m_data_addr   = 32'h20;
        m_data_byteen = 4'b1111;
        m_data_wdata  = 32'd5;
        #1;
        check("raw_same_cycle", m_data_rdata, 32'h0);
        @(negedge Clk);
        m_data_byteen = 4'b0000;
        #1;
        check("raw_next_cycle", m_data_rdata, 32'd5);

        // Decode boundaries
        wr(32'h2FFC, 4'b1111, 32'hCAFE_F00D);
        rd("dm_last_word", 32'h2FFC, 32'hCAFE_F00D);
        wr(32'h3000, 4'b1111, 32'hDEAD_BEEF);
        rd("unmapped_above_dm", 32'h3000, 32'h0);
        rd("dm_word0_untouched", 32'h0, 32'h0);
        wr(TC, 4'b0011, 32'h0000_000F);
        rd("tc_partial_ctrl", TC, 32'h0);
        wr(TC + 4, 4'b1110, 32'h1234_5678);
        rd("tc_partial_preset", TC + 4, 32'h0);
        rd("tc_hole_0c", TC + 12, 32'h0);
        rd("unmapped_high", 32'h4000_0000, 32'h0);
        wr(TC, 4'b1111, 32'hFFFF_FFF0);
        rd("ctrl_upper_zero", TC, 32'h0000_0000);

        // One-shot: PRESET=3, CTRL=EN|IM
        wr(TC + 4, 4'b1111, 32'd3);
        rd("preset_rd", TC + 4, 32'd3);
        wr(TC, 4'b1111, 32'h9);
        rd("os_idle_count", TC + 8, 32'd0);
        @(negedge Clk);
        rd("os_load_count", TC + 8, 32'd0);
        @(negedge Clk);
        rd("os_count3", TC + 8, 32'd3);
        @(negedge Clk);
        rd("os_count2", TC + 8, 32'd2);
        wr(TC + 8, 4'b1111, 32'h55);
        rd("os_count_ro", TC + 8, 32'd1);
        @(negedge Clk);
        rd("os_count0", TC + 8, 32'd0);
        chk_irq("os_irq_at0", 1'b0);
        @(negedge Clk);
        chk_irq("os_irq_lag", 1'b0);
        @(negedge Clk);
        chk_irq("os_irq_set", 1'b1);
        rd("os_ctrl_en_cleared", TC, 32'h8);
        repeat (3) @(negedge Clk);
        chk_irq("os_irq_held", 1'b1);
        rd("os_count_stays0", TC + 8, 32'd0);
        wr(TC, 4'b1111, 32'h0);
        chk_irq("os_irq_clear_lag", 1'b1);
        @(negedge Clk);
        chk_irq("os_irq_cleared", 1'b0);

        // Auto-reload: PRESET=2, CTRL=EN|MODE01|IM -> irq high 6 and 11 edges after the write
        wr(TC + 4, 4'b1111, 32'd2);
        wr(TC, 4'b1111, 32'hB);
        for (int k = 1; k <= 11; k++) begin
            @(negedge Clk);
            chk_irq($sformatf("ar_irq_k%0d", k), (k == 6) || (k == 11));
        end
        rd("ar_ctrl_en_kept", TC, 32'hB);

        // Reset asserted while the timer is in LOAD (COUNT would become 2)
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        rd("rst_mid_count", TC + 8, 32'd0);
        chk_irq("rst_mid_irq", 1'b0);
        rd("rst_mid_ctrl", TC, 32'h0);
        rd("rst_mid_preset", TC + 4, 32'h0);
        rd("rst_mid_dm", 32'h10, 32'h0);
        repeat (3) @(negedge Clk);
        rd("rst_idle_count", TC + 8, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
